// File: rtl/ycbcr_src_sched.sv
// Frame-granular scheduler that shares one rgb2ycbcr converter between two RGB sources.
// Tags converter output pixels with their owning source and reports per-frame pixel counts.
//
// state | meaning
// IDLE  | nothing granted, waiting for a request
// ARM   | source granted, converter blanked until its next vsync rise
// RUN   | forwarding the granted source, frame report at each vsync rise
// DRAIN | blanked for LAT+1 cycles while the converter pipe empties
module ycbcr_src_sched #(
  parameter int LAT   = 3,
  parameter int CNT_W = 22
) (
  input  logic             pixelclk,
  input  logic             rst,
  input  logic             s0_req,
  input  logic             s1_req,
  input  logic [23:0]      s0_rgb,
  input  logic             s0_hsync,
  input  logic             s0_vsync,
  input  logic             s0_de,
  input  logic [23:0]      s1_rgb,
  input  logic             s1_hsync,
  input  logic             s1_vsync,
  input  logic             s1_de,
  output logic [23:0]      c_rgb,
  output logic             c_hsync,
  output logic             c_vsync,
  output logic             c_de,
  input  logic             conv_de,
  output logic             o_owner,
  output logic             o_owner_vld,
  output logic [1:0]       grant,
  output logic             frame_done,
  output logic             frame_src,
  output logic [CNT_W-1:0] frame_pix_cnt,
  output logic             tag_err
);

  typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_t;

  localparam int               TW      = $clog2(LAT + 1);
  localparam logic [TW-1:0]    T_LAT   = TW'(LAT);
  localparam logic [TW-1:0]    T_ONE   = TW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state;
  logic             sel;
  logic             rr;
  logic             prev_vs;
  logic             c_src;
  logic [TW-1:0]    drain_tmr;
  logic [TW-1:0]    mask_tmr;
  logic [CNT_W-1:0] cnt;
  logic [LAT-1:0]   tag_vld;
  logic [LAT-1:0]   tag_src;

  logic [23:0]      f_rgb;
  logic             f_hs;
  logic             f_vs;
  logic             f_de;
  logic             own_req;
  logic             oth_req;
  logic             rise;
  logic             pick;
  logic [CNT_W-1:0] cnt_de;
  logic [CNT_W-1:0] cnt_inc;

  function automatic logic [1:0] onehot(input logic s);
    return s ? 2'b10 : 2'b01;
  endfunction

  always_comb begin
    f_rgb   = sel ? s1_rgb   : s0_rgb;
    f_hs    = sel ? s1_hsync : s0_hsync;
    f_vs    = sel ? s1_vsync : s0_vsync;
    f_de    = sel ? s1_de    : s0_de;
    own_req = sel ? s1_req   : s0_req;
    oth_req = sel ? s0_req   : s1_req;
    rise    = f_vs & ~prev_vs;
    pick    = (s0_req & s1_req) ? rr : s1_req;
    cnt_de  = {{(CNT_W-1){1'b0}}, f_de};
    cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + cnt_de;
  end

  always_ff @(posedge pixelclk) begin
    if (rst) begin
      state         <= IDLE;
      sel           <= 1'b0;
      rr            <= 1'b0;
      prev_vs       <= 1'b0;
      c_src         <= 1'b0;
      drain_tmr     <= '0;
      cnt           <= '0;
      grant         <= 2'b00;
      c_rgb         <= '0;
      c_hsync       <= 1'b0;
      c_vsync       <= 1'b0;
      c_de          <= 1'b0;
      frame_done    <= 1'b0;
      frame_src     <= 1'b0;
      frame_pix_cnt <= '0;
    end else begin
      // blank by default; forwarding branches override
      frame_done <= 1'b0;
      c_rgb      <= '0;
      c_hsync    <= 1'b0;
      c_vsync    <= 1'b0;
      c_de       <= 1'b0;
      c_src      <= sel;
      prev_vs    <= f_vs;
      unique case (state)
        IDLE: begin
          if (s0_req | s1_req) begin
            sel   <= pick;
            grant <= onehot(pick);
            state <= ARM;
            if (pick != sel) prev_vs <= 1'b0;
          end
        end
        ARM: begin
          if (rise) begin
            c_rgb   <= f_rgb;
            c_hsync <= f_hs;
            c_vsync <= f_vs;
            c_de    <= f_de;
            cnt     <= cnt_de;
            state   <= RUN;
          end
        end
        RUN: begin
          if (rise) begin
            frame_done    <= 1'b1;
            frame_src     <= sel;
            frame_pix_cnt <= cnt;
            if (oth_req | ~own_req) begin
              grant     <= 2'b00;
              rr        <= ~sel;
              drain_tmr <= T_LAT;
              state     <= DRAIN;
            end else begin
              c_rgb   <= f_rgb;
              c_hsync <= f_hs;
              c_vsync <= f_vs;
              c_de    <= f_de;
              cnt     <= cnt_de;
            end
          end else begin
            c_rgb   <= f_rgb;
            c_hsync <= f_hs;
            c_vsync <= f_vs;
            c_de    <= f_de;
            cnt     <= cnt_inc;
          end
        end
        DRAIN: begin
          if (drain_tmr == '0) begin
            if (oth_req) begin
              sel     <= ~sel;
              prev_vs <= 1'b0;
              grant   <= onehot(~sel);
              state   <= ARM;
            end else if (own_req) begin
              grant <= onehot(sel);
              state <= ARM;
            end else begin
              state <= IDLE;
            end
          end else begin
            drain_tmr <= drain_tmr - T_ONE;
          end
        end
      endcase
    end
  end

  // The converter has no reset, so its output is untrustworthy for LAT cycles after rst.
  always_ff @(posedge pixelclk) begin
    if (rst) begin
      tag_vld  <= '0;
      tag_src  <= '0;
      mask_tmr <= T_LAT;
      tag_err  <= 1'b0;
    end else begin
      tag_vld[0] <= c_de;
      tag_src[0] <= c_src;
      for (int i = 1; i < LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_src[i] <= tag_src[i-1];
      end
      if (mask_tmr != '0) mask_tmr <= mask_tmr - T_ONE;
      else if (conv_de != tag_vld[LAT-1]) tag_err <= 1'b1;
    end
  end

  assign o_owner     = tag_src[LAT-1];
  assign o_owner_vld = conv_de & tag_vld[LAT-1];

endmodule

// File: tb/tb_ycbcr_src_sched.sv
// Randomized scoreboard bench for ycbcr_src_sched: a frame-rule reference model predicts
// forwarded pixels, frame reports and owner tags; a monitor pops and compares.
`timescale 1ns/1ps
module tb_ycbcr_src_sched;
  localparam int LAT   = 3;
  localparam int CNT_W = 22;

  logic pixelclk = 1'b0;
  always #5 pixelclk = ~pixelclk;

  logic        rst = 1'b1;
  logic        s0_req = 1'b0, s1_req = 1'b0;
  logic [23:0] s0_rgb = '0, s1_rgb = '0;
  logic        s0_hsync = 1'b0, s0_vsync = 1'b0, s0_de = 1'b0;
  logic        s1_hsync = 1'b0, s1_vsync = 1'b0, s1_de = 1'b0;
  logic        glitch = 1'b0;
  logic [LAT-1:0] conv_pipe = '0;
  logic        conv_de;

  logic [23:0] c_rgb, c_rgb4;
  logic        c_hsync, c_vsync, c_de, c_hsync4, c_vsync4, c_de4;
  logic        o_owner, o_owner_vld, o_owner4, o_owner_vld4;
  logic [1:0]  grant, grant4;
  logic        frame_done, frame_src, frame_done4, frame_src4;
  logic [CNT_W-1:0] frame_pix_cnt;
  logic [3:0]  frame_pix_cnt4;
  logic        tag_err, tag_err4;

  ycbcr_src_sched #(.LAT(LAT), .CNT_W(CNT_W)) dut (
    .pixelclk(pixelclk), .rst(rst), .s0_req(s0_req), .s1_req(s1_req),
    .s0_rgb(s0_rgb), .s0_hsync(s0_hsync), .s0_vsync(s0_vsync), .s0_de(s0_de),
    .s1_rgb(s1_rgb), .s1_hsync(s1_hsync), .s1_vsync(s1_vsync), .s1_de(s1_de),
    .c_rgb(c_rgb), .c_hsync(c_hsync), .c_vsync(c_vsync), .c_de(c_de),
    .conv_de(conv_de), .o_owner(o_owner), .o_owner_vld(o_owner_vld), .grant(grant),
    .frame_done(frame_done), .frame_src(frame_src), .frame_pix_cnt(frame_pix_cnt),
    .tag_err(tag_err));

  ycbcr_src_sched #(.LAT(LAT), .CNT_W(4)) dut4 (
    .pixelclk(pixelclk), .rst(rst), .s0_req(s0_req), .s1_req(s1_req),
    .s0_rgb(s0_rgb), .s0_hsync(s0_hsync), .s0_vsync(s0_vsync), .s0_de(s0_de),
    .s1_rgb(s1_rgb), .s1_hsync(s1_hsync), .s1_vsync(s1_vsync), .s1_de(s1_de),
    .c_rgb(c_rgb4), .c_hsync(c_hsync4), .c_vsync(c_vsync4), .c_de(c_de4),
    .conv_de(conv_de), .o_owner(o_owner4), .o_owner_vld(o_owner_vld4), .grant(grant4),
    .frame_done(frame_done4), .frame_src(frame_src4), .frame_pix_cnt(frame_pix_cnt4),
    .tag_err(tag_err4));

  // converter stand-in: de delayed by LAT, no reset
  always @(posedge pixelclk) conv_pipe <= {conv_pipe[LAT-2:0], (c_de === 1'b1)};
  assign conv_de = conv_pipe[LAT-1] | glitch;

  int n_chk = 0, n_pass = 0, frames_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic timeout(input string name);
    n_chk++;
    $display("FAIL %s: timed out waiting, got no event expected one at %0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_ARM = 1, M_RUN = 2, M_DRAIN = 3;
  int          m_phase = M_IDLE, m_left = 0, rst_win = 0;
  bit          m_src = 1'b0, m_turn = 1'b0, m_vs_prev = 1'b0;
  int unsigned m_pix = 0;
  logic [1:0]  m_grant = 2'b00;
  logic [25:0] pix_q[$];
  logic [22:0] frame_q[$];
  bit          owner_q[$];

  always @(posedge pixelclk) begin : model
    bit vs, hs, de, mine, other, start, fwd, nsrc;
    logic [23:0] rgb;
    if (rst) begin
      m_phase = M_IDLE; m_src = 1'b0; m_turn = 1'b0; m_vs_prev = 1'b0;
      m_pix = 0; m_grant = 2'b00; rst_win = LAT;
      owner_q.delete();
    end else begin
      if (rst_win > 0) rst_win--;
      vs    = m_src ? s1_vsync : s0_vsync;
      hs    = m_src ? s1_hsync : s0_hsync;
      de    = m_src ? s1_de    : s0_de;
      rgb   = m_src ? s1_rgb   : s0_rgb;
      mine  = m_src ? s1_req   : s0_req;
      other = m_src ? s0_req   : s1_req;
      start = vs && !m_vs_prev;
      fwd   = 1'b0;
      nsrc  = m_src;
      case (m_phase)
        M_IDLE: if (s0_req || s1_req) begin
          nsrc = (s0_req && s1_req) ? m_turn : s1_req;
          m_phase = M_ARM;
        end
        M_ARM: if (start) begin
          fwd = 1'b1; m_pix = de; m_phase = M_RUN;
        end
        M_RUN: if (start) begin
          frame_q.push_back({m_src, m_pix[21:0]});
          if (other || !mine) begin
            m_phase = M_DRAIN; m_turn = !m_src; m_left = LAT + 1;
          end else begin
            fwd = 1'b1; m_pix = de;
          end
        end else begin
          fwd = 1'b1;
          if (de && m_pix < (1 << CNT_W) - 1) m_pix++;
        end
        default: begin
          m_left--;
          if (m_left == 0) begin
            if (other) begin nsrc = !m_src; m_phase = M_ARM; end
            else if (mine) m_phase = M_ARM;
            else m_phase = M_IDLE;
          end
        end
      endcase
      if (fwd && de) begin
        pix_q.push_back({rgb, hs, vs});
        owner_q.push_back(m_src);
      end
      m_vs_prev = (nsrc != m_src) ? 1'b0 : vs;
      m_src = nsrc;
      m_grant = (m_phase == M_ARM || m_phase == M_RUN) ? (m_src ? 2'b10 : 2'b01) : 2'b00;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge pixelclk) begin : monitor
    logic [25:0] ep;
    logic [22:0] ef;
    bit eo;
    chk("grant", grant, m_grant);
    chk("grant4", grant4, m_grant);
    if (c_de) begin
      if (pix_q.size() == 0) chk("c_de_leak", c_de, 1'b0);
      else begin
        ep = pix_q.pop_front();
        chk("c_pix", {c_rgb, c_hsync, c_vsync}, ep);
        chk("c_pix4", {c_rgb4, c_hsync4, c_vsync4, c_de4}, {ep, 1'b1});
      end
    end else chk("c_de4_idle", c_de4, 1'b0);
    if (frame_done) begin
      if (frame_q.size() == 0) chk("frame_done_spurious", frame_done, 1'b0);
      else begin
        ef = frame_q.pop_front();
        chk("frame_src", frame_src, ef[22]);
        chk("frame_pix_cnt", frame_pix_cnt, ef[21:0]);
        chk("frame_done4", frame_done4, 1'b1);
        chk("frame_src4", frame_src4, ef[22]);
        chk("frame_pix_cnt4", frame_pix_cnt4, (ef[21:0] > 22'd15) ? 64'd15 : 64'(ef[21:0]));
        frames_seen++;
      end
    end
    if (rst_win == 0) begin
      if (conv_de) begin
        chk("o_owner_vld", o_owner_vld, 1'b1);
        chk("o_owner_vld4", o_owner_vld4, 1'b1);
        if (owner_q.size() == 0) chk("conv_de_untagged", conv_de, 1'b0);
        else begin
          eo = owner_q.pop_front();
          chk("o_owner", o_owner, eo);
          chk("o_owner4", o_owner4, eo);
        end
      end else begin
        chk("o_owner_vld_idle", o_owner_vld, 1'b0);
        chk("o_owner_vld4_idle", o_owner_vld4, 1'b0);
      end
      chk("tag_err", tag_err, 1'b0);
      chk("tag_err4", tag_err4, 1'b0);
    end
  end

  // ---------------- sources ----------------
  bit fix_en[2];
  int fix_w[2], fix_h[2];

  task automatic drive(input int n, input bit vs, input bit hs, input bit de);
    logic [23:0] px;
    px = de ? 24'($urandom) : 24'h0;
    @(negedge pixelclk);
    if (n == 0) begin s0_vsync = vs; s0_hsync = hs; s0_de = de; s0_rgb = px; end
    else        begin s1_vsync = vs; s1_hsync = hs; s1_de = de; s1_rgb = px; end
  endtask

  task automatic run_src(input int n);
    int w, h;
    if (n == 0) repeat (40) drive(0, 1'b1, 1'b0, 1'b0);
    forever begin
      w = fix_en[n] ? fix_w[n] : int'($urandom_range(8, 2));
      h = fix_en[n] ? fix_h[n] : int'($urandom_range(4, 1));
      repeat (2) drive(n, 1'b1, 1'b0, 1'b0);
      repeat ($urandom_range(3, 1)) drive(n, 1'b0, 1'b0, 1'b0);
      for (int y = 0; y < h; y++) begin
        for (int x = 0; x < w; x++) drive(n, 1'b0, 1'b0, 1'b1);
        drive(n, 1'b0, 1'b1, 1'b0);
        drive(n, 1'b0, 1'b0, 1'b0);
      end
      repeat ($urandom_range(4, 1)) drive(n, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic wait_frames(input int n, input int budget);
    int start, k;
    start = frames_seen;
    k = 0;
    while (frames_seen < start + n && k < budget) begin @(negedge pixelclk); k++; end
    if (frames_seen < start + n) timeout("wait_frames");
  endtask

  // ---------------- sequence ----------------
  initial begin
    int k;
    fix_en[0] = 1'b1; fix_w[0] = 4; fix_h[0] = 2;
    fix_en[1] = 1'b0; fix_w[1] = 0; fix_h[1] = 0;
    fork
      run_src(0);
      run_src(1);
    join_none

    repeat (3) @(negedge pixelclk);
    chk("rst_c_rgb", c_rgb, 24'h0);
    chk("rst_c_sync", {c_hsync, c_vsync, c_de}, 3'b000);
    chk("rst_owner", {o_owner, o_owner_vld}, 2'b00);
    chk("rst_grant", grant, 2'b00);
    chk("rst_frame", {frame_done, frame_src}, 2'b00);
    chk("rst_frame_pix_cnt", frame_pix_cnt, 0);
    chk("rst_tag_err", tag_err, 1'b0);
    rst = 1'b0; glitch = 1'b1;
    s0_req = 1'b1;
    @(negedge pixelclk);
    glitch = 1'b0;

    // s0 vsync still held high from reset: granted but blanked
    repeat (10) @(negedge pixelclk);
    chk("arm_hold_grant", grant, 2'b01);
    chk("arm_hold_blank", {c_vsync, c_de}, 2'b00);

    wait_frames(2, 1500);

    // s1 requests mid s0 frame
    k = 0;
    while (!c_de && k < 500) begin @(negedge pixelclk); k++; end
    if (!c_de) timeout("s0_pixel");
    s1_req = 1'b1;
    k = 0;
    while (grant != 2'b10 && k < 500) begin @(negedge pixelclk); k++; end
    if (grant != 2'b10) timeout("s1_grant");
    wait_frames(4, 3000);

    // oversized s0 frame saturates the narrow counter
    s1_req = 1'b0;
    fix_w[0] = 7; fix_h[0] = 3;
    wait_frames(3, 3000);
    fix_en[0] = 1'b0;

    for (int i = 0; i < 40; i++) begin
      s0_req = ($urandom_range(3, 0) != 0);
      s1_req = ($urandom_range(3, 0) != 0);
      repeat ($urandom_range(150, 20)) @(negedge pixelclk);
    end

    // reset mid-frame in RUN
    s0_req = 1'b1; s1_req = 1'b0;
    k = 0;
    while (!(grant != 2'b00 && c_de) && k < 3000) begin @(negedge pixelclk); k++; end
    if (!(grant != 2'b00 && c_de)) timeout("mid_frame");
    rst = 1'b1;
    @(negedge pixelclk);
    chk("midrst_grant", grant, 2'b00);
    chk("midrst_c_de", c_de, 1'b0);
    chk("midrst_frame_done", frame_done, 1'b0);
    rst = 1'b0; glitch = 1'b1;
    @(negedge pixelclk);
    glitch = 1'b0;
    wait_frames(2, 1500);

    s0_req = 1'b0; s1_req = 1'b0;
    repeat (300) @(negedge pixelclk);
    chk("pix_q_drained", pix_q.size(), 0);
    chk("frame_q_drained", frame_q.size(), 0);
    chk("owner_q_drained", owner_q.size(), 0);
    chk("final_tag_err", {tag_err, tag_err4}, 2'b00);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
